// File: rtl/pvci_can_pkg.sv
// ============================================================================
//  Package : pvci_can_pkg
//  Brief   : Register map, control/status bit positions and the CAN TX frame
//            type shared by the PVCI CAN transmit buffer.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pvci_can_pkg;

    localparam logic [7:0] c_ADDR_CTRL   = 8'h00;
    localparam logic [7:0] c_ADDR_STATUS = 8'h01;
    localparam logic [7:0] c_ADDR_LEVEL  = 8'h02;
    localparam logic [7:0] c_ADDR_ID_HI  = 8'h03;
    localparam logic [7:0] c_ADDR_ID_LO  = 8'h04;
    localparam logic [7:0] c_ADDR_DATA0  = 8'h05;
    localparam logic [7:0] c_ADDR_DATA7  = 8'h0C;
    localparam logic [7:0] c_ADDR_IRQ_EN = 8'h0D;

    localparam int c_CTRL_COMMIT  = 0;
    localparam int c_CTRL_FLUSH   = 1;
    localparam int c_CTRL_CLR_OVF = 2;

    localparam int c_STAT_FULL  = 0;
    localparam int c_STAT_EMPTY = 1;
    localparam int c_STAT_OVF   = 2;
    localparam int c_STAT_IRQ   = 3;

    typedef struct packed {
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } can_frame_t;

    localparam int FRAME_W = $bits(can_frame_t);

endpackage

`default_nettype wire

// File: rtl/can_frame_fifo.sv
// ============================================================================
//  Module  : can_frame_fifo
//  Brief   : DEPTH x WIDTH register-array FIFO with flush and simultaneous
//            push/pop, including push into a full FIFO when the head pops.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module can_frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 80,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level,
    output logic [WIDTH-1:0] o_head
);

    localparam logic [AW-1:0] c_PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   c_LVL_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   c_LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_full    = (r_level == c_LVL_FULL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves at the same edge.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pvci_can_txbuf.sv
// ============================================================================
//  Module  : pvci_can_txbuf
//  Brief   : PVCI register slave that stages CAN TX frames and commits them
//            into a frame FIFO drained by the CAN core via valid/ready.
//            Optional empty interrupt: define CAN_TXBUF_IRQ_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pvci_can_txbuf
    import pvci_can_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic [7:0]  pvci_addr,
    input  logic [7:0]  pvci_wd,
    input  logic        pvci_valid,
    input  logic        pvci_rd,
    output logic [7:0]  pvci_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [10:0] tx_id,
    output logic        tx_rtr,
    output logic [3:0]  tx_dlc,
    output logic [63:0] tx_data
`ifdef CAN_TXBUF_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int          LW        = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] c_LVL_ONE = {{(LW-1){1'b0}}, 1'b1};

    logic [7:0] r_id_hi;
    logic [7:0] r_id_lo;
    logic [7:0] r_data [8];
    logic       r_ovf;

    logic          w_wr;
    logic          w_ctrl_wr;
    logic          w_commit;
    logic          w_flush;
    logic          w_clr_ovf;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;
    logic          w_data_hit;
    logic [2:0]    w_data_idx;
    logic          w_ovf_set;
    logic          w_irq_pend;
    can_frame_t    w_stage;
    can_frame_t    w_head;

    assign w_wr       = pvci_valid & ~pvci_rd;
    assign w_ctrl_wr  = w_wr && (pvci_addr == c_ADDR_CTRL);
    assign w_commit   = w_ctrl_wr & pvci_wd[c_CTRL_COMMIT];
    assign w_flush    = w_ctrl_wr & pvci_wd[c_CTRL_FLUSH];
    assign w_clr_ovf  = w_ctrl_wr & pvci_wd[c_CTRL_CLR_OVF];
    assign w_pop      = tx_valid & tx_ready;
    assign w_data_hit = (pvci_addr >= c_ADDR_DATA0) && (pvci_addr <= c_ADDR_DATA7);
    // Low three address bits minus 5 wrap to 0..7 over the DATA window.
    assign w_data_idx = pvci_addr[2:0] - 3'd5;
    assign w_ovf_set  = w_commit & ~w_flush & w_full & ~w_pop;

    assign w_stage.id   = {r_id_hi, r_id_lo[7:5]};
    assign w_stage.rtr  = r_id_lo[4];
    assign w_stage.dlc  = r_id_lo[3:0];
    assign w_stage.data = {r_data[7], r_data[6], r_data[5], r_data[4],
                           r_data[3], r_data[2], r_data[1], r_data[0]};

    can_frame_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FRAME_W)
    ) u_fifo (
        .clk     (pclk),
        .rst_n   (presetn),
        .i_push  (w_commit & ~w_flush),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_stage),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level),
        .o_head  (w_head)
    );

    // Head fields are forced to zero whenever no frame is presented.
    assign tx_valid = ~w_empty;
    assign tx_id    = tx_valid ? w_head.id   : '0;
    assign tx_rtr   = tx_valid ? w_head.rtr  : 1'b0;
    assign tx_dlc   = tx_valid ? w_head.dlc  : '0;
    assign tx_data  = tx_valid ? w_head.data : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_id_hi <= '0;
            r_id_lo <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_wr && (pvci_addr == c_ADDR_ID_HI)) r_id_hi <= pvci_wd;
            if (w_wr && (pvci_addr == c_ADDR_ID_LO)) r_id_lo <= pvci_wd;
            if (w_wr && w_data_hit) r_data[w_data_idx] <= pvci_wd;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef CAN_TXBUF_IRQ_EN
    logic r_irq_en;
    logic r_irq_pend;
    logic r_irq;
    logic w_to_empty;
    logic w_pend_clr;

    // Only a pop that leaves the FIFO empty raises the interrupt; a flush does not.
    assign w_to_empty = w_pop & ~w_flush & ~w_commit & (w_level == c_LVL_ONE);
    assign w_pend_clr = w_wr && (pvci_addr == c_ADDR_STATUS) && pvci_wd[c_STAT_IRQ];
    assign w_irq_pend = r_irq_pend;
    assign irq        = r_irq;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_irq_en   <= 1'b0;
            r_irq_pend <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && (pvci_addr == c_ADDR_IRQ_EN)) r_irq_en <= pvci_wd[0];
            if (w_to_empty) begin
                r_irq_pend <= 1'b1;
            end else if (w_pend_clr) begin
                r_irq_pend <= 1'b0;
            end
            r_irq <= r_irq_pend & r_irq_en;
        end
    end
`else
    assign w_irq_pend = 1'b0;
`endif

    always_comb begin
        pvci_rdata = 8'h00;
        case (pvci_addr)
            c_ADDR_STATUS: pvci_rdata = {4'b0000, w_irq_pend, r_ovf, w_empty, w_full};
            c_ADDR_LEVEL:  pvci_rdata = 8'(w_level);
            c_ADDR_ID_HI:  pvci_rdata = r_id_hi;
            c_ADDR_ID_LO:  pvci_rdata = r_id_lo;
`ifdef CAN_TXBUF_IRQ_EN
            c_ADDR_IRQ_EN: pvci_rdata = {7'b0000000, r_irq_en};
`endif
            default: begin
                if (w_data_hit) pvci_rdata = r_data[w_data_idx];
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_pvci_can_txbuf.sv
// ============================================================================
//  Module  : tb_pvci_can_txbuf
//  Brief   : Scoreboard bench for pvci_can_txbuf; committed frames are queued
//            and compared against the head at every valid/ready handshake.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pvci_can_txbuf;
    import pvci_can_pkg::*;

    localparam int DEPTH = 4;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [7:0]  pvci_addr = '0;
    logic [7:0]  pvci_wd = '0;
    logic        pvci_valid = 1'b0;
    logic        pvci_rd = 1'b0;
    logic [7:0]  pvci_rdata;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [10:0] tx_id;
    logic        tx_rtr;
    logic [3:0]  tx_dlc;
    logic [63:0] tx_data;
`ifdef CAN_TXBUF_IRQ_EN
    logic        irq;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    can_frame_t sb_q[$];
    can_frame_t stg;

    always #5 pclk = ~pclk;

    pvci_can_txbuf #(.DEPTH(DEPTH)) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .pvci_addr  (pvci_addr),
        .pvci_wd    (pvci_wd),
        .pvci_valid (pvci_valid),
        .pvci_rd    (pvci_rd),
        .pvci_rdata (pvci_rdata),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_id      (tx_id),
        .tx_rtr     (tx_rtr),
        .tx_dlc     (tx_dlc),
        .tx_data    (tx_data)
`ifdef CAN_TXBUF_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge pclk);
        pvci_addr  = a;
        pvci_wd    = d;
        pvci_rd    = 1'b0;
        pvci_valid = 1'b1;
        @(negedge pclk);
        pvci_valid = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
        pvci_addr = a;
        pvci_rd   = 1'b1;
        #1;
        chk(tag, {72'd0, pvci_rdata}, {72'd0, exp});
    endtask

    task automatic set_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] data);
        wr(c_ADDR_ID_HI, id[10:3]);
        wr(c_ADDR_ID_LO, {id[2:0], rtr, dlc});
        for (int i = 0; i < 8; i++) begin
            wr(c_ADDR_DATA0 + 8'(i), data[8*i +: 8]);
        end
        stg = '{id: id, rtr: rtr, dlc: dlc, data: data};
    endtask

    // CTRL write; the model decides acceptance from occupancy and same-cycle pop.
    task automatic commit(input logic [7:0] ctrl, input logic pop_too);
        @(negedge pclk);
        pvci_addr  = c_ADDR_CTRL;
        pvci_wd    = ctrl;
        pvci_rd    = 1'b0;
        pvci_valid = 1'b1;
        tx_ready   = pop_too;
        if (ctrl[1]) begin
            sb_q.delete();
        end else if (ctrl[0] && (sb_q.size() < DEPTH || (pop_too && sb_q.size() > 0))) begin
            sb_q.push_back(stg);
        end
        @(negedge pclk);
        pvci_valid = 1'b0;
        tx_ready   = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        @(negedge pclk);
        tx_ready = 1'b1;
        while (tx_valid && cyc < 40) begin
            @(negedge pclk);
            cyc++;
        end
        tx_ready = 1'b0;
        chk("drain_timeout", {79'd0, cyc < 40}, 80'd1);
        chk("sb_leftover", 80'(sb_q.size()), 80'd0);
    endtask

    // Handshake qualifying the coming rising edge, sampled mid-cycle.
    always @(negedge pclk) begin
        can_frame_t exp_f;
        #1;
        if (presetn && tx_valid && tx_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pop", 80'd1, 80'd0);
            end else begin
                exp_f = sb_q.pop_front();
                chk("tx_frame", {tx_id, tx_rtr, tx_dlc, tx_data}, exp_f);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);

        // Reset state
        chk_reg("rst_status", c_ADDR_STATUS, 8'h02);
        chk_reg("rst_level",  c_ADDR_LEVEL,  8'h00);
        chk("rst_tx_valid", {79'd0, tx_valid}, 80'd0);
        chk("rst_tx_data", {16'd0, tx_data}, 80'd0);
        for (int i = 0; i < 8; i++) begin
            chk_reg("rst_data", c_ADDR_DATA0 + 8'(i), 8'h00);
        end

        // Single frame, stalled core, then pop
        set_frame(11'h48B, 1'b0, 4'd8, 64'h8877665544332211);
        chk_reg("id_hi_rb", c_ADDR_ID_HI, 8'h91);
        chk_reg("id_lo_rb", c_ADDR_ID_LO, 8'h68);
        chk_reg("data7_rb", c_ADDR_DATA7, 8'h88);
        commit(8'h01, 1'b0);
        chk("t2_valid", {79'd0, tx_valid}, 80'd1);
        chk("t2_id",  {69'd0, tx_id},  {69'd0, 11'h48B});
        chk("t2_rtr", {79'd0, tx_rtr}, 80'd0);
        chk("t2_dlc", {76'd0, tx_dlc}, 80'd8);
        chk("t2_data", {16'd0, tx_data}, {16'd0, 64'h8877665544332211});
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            chk("t2_hold", {15'd0, tx_valid, tx_data}, {15'd0, 1'b1, 64'h8877665544332211});
        end
        drain();
        chk_reg("t2_status", c_ADDR_STATUS, 8'h02);

        // Fill, overflow combined with clear-overflow, clear, drain in order
        for (int i = 0; i < 5; i++) begin
            set_frame(11'h100 + 11'(i * 'h155), i[0], 4'(11 + i),
                      {8{8'(8'h21 * (i + 1))}} ^ 64'h0123456789ABCDEF);
            commit((i == 4) ? 8'h05 : 8'h01, 1'b0);
            if (i == 3) begin
                chk_reg("t3_full_status", c_ADDR_STATUS, 8'h01);
                chk_reg("t3_full_level",  c_ADDR_LEVEL,  8'h04);
            end
        end
        chk_reg("t3_ovf_status", c_ADDR_STATUS, 8'h05);
        chk_reg("t3_ovf_level",  c_ADDR_LEVEL,  8'h04);
        wr(c_ADDR_CTRL, 8'h04);
        chk_reg("t3_clr_status", c_ADDR_STATUS, 8'h01);
        drain();
        chk_reg("t3_end_status", c_ADDR_STATUS, 8'h02);

        // Commit into a full FIFO in the same cycle as a pop
        for (int i = 0; i < 4; i++) begin
            set_frame(11'h7F0 - 11'(i), 1'b1, 4'(i), 64'hA5A5_0000_0000_0000 | 64'(i));
            commit(8'h01, 1'b0);
        end
        set_frame(11'h2AA, 1'b0, 4'd15, 64'hDEAD_BEEF_CAFE_F00D);
        commit(8'h01, 1'b1);
        chk_reg("t4_level",  c_ADDR_LEVEL,  8'h04);
        chk_reg("t4_status", c_ADDR_STATUS, 8'h01);
        drain();

        // Flush plus commit with frames queued and core stalled
        set_frame(11'h011, 1'b0, 4'd2, 64'h1);
        commit(8'h01, 1'b0);
        commit(8'h01, 1'b0);
        commit(8'h03, 1'b0);
        chk("t5_valid", {79'd0, tx_valid}, 80'd0);
        chk_reg("t5_level",  c_ADDR_LEVEL,  8'h00);
        chk_reg("t5_status", c_ADDR_STATUS, 8'h02);
        chk_reg("t5_unmapped", 8'h3F, 8'h00);
        chk_reg("t5_ctrl_rd", c_ADDR_CTRL, 8'h00);

        // Asynchronous reset while a frame is presented
        commit(8'h01, 1'b0);
        chk("t7_pre_valid", {79'd0, tx_valid}, 80'd1);
        #2 presetn = 1'b0;
        sb_q.delete();
        #1;
        chk("t7_async_valid", {79'd0, tx_valid}, 80'd0);
        chk_reg("t7_id_hi", c_ADDR_ID_HI, 8'h00);
        @(negedge pclk);
        presetn = 1'b1;
        chk_reg("t7_status", c_ADDR_STATUS, 8'h02);

`ifdef CAN_TXBUF_IRQ_EN
        wr(c_ADDR_IRQ_EN, 8'h01);
        chk_reg("t6_irq_en", c_ADDR_IRQ_EN, 8'h01);
        set_frame(11'h123, 1'b0, 4'd1, 64'h5A);
        commit(8'h01, 1'b0);
        drain();
        @(negedge pclk);
        chk("t6_irq_set", {79'd0, irq}, 80'd1);
        chk_reg("t6_status_pend", c_ADDR_STATUS, 8'h0A);
        wr(c_ADDR_STATUS, 8'h08);
        @(negedge pclk);
        chk("t6_irq_clr", {79'd0, irq}, 80'd0);
        chk_reg("t6_status_clr", c_ADDR_STATUS, 8'h02);
`else
        set_frame(11'h123, 1'b0, 4'd1, 64'h5A);
        commit(8'h01, 1'b0);
        drain();
        wr(c_ADDR_STATUS, 8'h08);
        chk_reg("t6_status_b3", c_ADDR_STATUS, 8'h02);
        wr(c_ADDR_IRQ_EN, 8'h01);
        chk_reg("t6_irq_en_unmapped", c_ADDR_IRQ_EN, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
